uart_tx_tick: RTL and testbench

//  Serial UART transmitter paced by a one-cycle baud tick from the divide-by-N counter.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_tick.sv | 136 +++++++++++++
 tb/tb_uart_tx_tick.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line-level constants,
// used by uart_tx_tick and the planned uart_rx.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } uart_state_e;

   localparam logic UART_IDLE_LEVEL    = 1'b1;
   localparam logic UART_START_LEVEL   = 1'b0;
   localparam int   UART_MAX_DATA_BITS = 8;
   localparam int   UART_MIN_DATA_BITS = 5;

endpackage

// File: rtl/uart_tx_tick.sv
// UART transmitter paced by an external one-cycle baud tick; LSB-first frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_tick
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int CNT_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

   uart_state_e          state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [CNT_W-1:0]     cnt_d;
   logic                 tx_q;
   logic                 ready_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 accept;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q;
`endif

   assign accept  = tx_valid && ready_q;
   assign shift_d = shift_q >> 1;
   assign cnt_d   = cnt_q + CNT_W'(1);

   // Every transition except the accept is gated by baud_tick, so each bit
   // lasts exactly one tick period once the frame leaves ARM.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         tx_q     <= UART_IDLE_LEVEL;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  shift_q  <= tx_data;
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^tx_data;
`endif
                  state_q  <= ST_ARM;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            ST_ARM: begin
               if (baud_tick) begin
                  state_q <= ST_START;
                  tx_q    <= UART_START_LEVEL;
               end
            end
            ST_START: begin
               if (baud_tick) begin
                  state_q <= ST_DATA;
                  cnt_q   <= '0;
                  tx_q    <= shift_q[0];
               end
            end
            ST_DATA: begin
               if (baud_tick) begin
                  shift_q <= shift_d;
                  cnt_q   <= cnt_d;
                  tx_q    <= shift_d[0];
                  if (cnt_q == DATA_LAST) begin
                     cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
                     state_q <= ST_PARITY;
                     tx_q    <= parity_q;
`else
                     state_q <= ST_STOP;
                     tx_q    <= UART_IDLE_LEVEL;
`endif
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (baud_tick) begin
                  state_q <= ST_STOP;
                  tx_q    <= UART_IDLE_LEVEL;
               end
            end
`endif
            ST_STOP: begin
               if (baud_tick) begin
                  if (cnt_q == STOP_LAST) begin
                     state_q <= ST_IDLE;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               tx_q    <= UART_IDLE_LEVEL;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Bench for uart_tx_tick: two instances (8N1 and 7 data / 2 stop), random and directed frames
// compared against a frame model built from the bit-order rules.
`timescale 1ns/1ps
module tb_uart_tx_tick;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset_n;
   logic       baud_tick;
   logic [7:0] tx_data;
   logic [6:0] tx_data_b;
   logic       tx_valid_a, tx_ready_a, tx_a, busy_a, done_a;
   logic       tx_valid_b, tx_ready_b, tx_b, busy_b, done_b;

   always #5 clock = ~clock;
   assign tx_data_b = tx_data[6:0];

   uart_tx_tick #(.DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
      .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(tx_data),
      .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a), .done(done_a));

   uart_tx_tick #(.DATA_BITS(7), .STOP_BITS(2)) u_dut_b (
      .clock(clock), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(tx_data_b),
      .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b), .done(done_b));

   // Selected instance seen by the monitor.
   logic sel = 1'b0;
   logic m_tx, m_busy, m_done, m_ready, m_valid;
   assign m_tx    = sel ? tx_b       : tx_a;
   assign m_busy  = sel ? busy_b     : busy_a;
   assign m_done  = sel ? done_b     : done_a;
   assign m_ready = sel ? tx_ready_b : tx_ready_a;
   assign m_valid = sel ? tx_valid_b : tx_valid_a;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Line levels seen at each tick while busy: ARM idle level, start, data LSB first,
   // optional even parity, stop bits.
   typedef struct {
      logic [15:0] bits;
      int          n;
   } frame_t;

   function automatic frame_t model_frame(input logic [7:0] d, input int db, input int sb);
      frame_t f;
      int     k;
      logic   par;
      f.bits    = '0;
      f.bits[0] = 1'b1;
      f.bits[1] = 1'b0;
      k   = 2;
      par = 1'b0;
      for (int i = 0; i < db; i++) begin
         f.bits[k] = d[i];
         par       = par ^ d[i];
         k++;
      end
      if (PAR) begin
         f.bits[k] = par;
         k++;
      end
      for (int i = 0; i < sb; i++) begin
         f.bits[k] = 1'b1;
         k++;
      end
      f.n = k;
      return f;
   endfunction

   // Free-running tick grid; period may be changed between frames.
   int tick_period = 4;
   int tick_cnt    = 0;
   initial begin
      baud_tick = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (tick_cnt >= tick_period - 1) begin
            tick_cnt  = 0;
            baud_tick = 1'b1;
         end else begin
            tick_cnt++;
            baud_tick = 1'b0;
         end
      end
   end

   frame_t      exp_q[$];
   logic [15:0] obs_bits = '0;
   logic [15:0] last_bits = '0;
   int          obs_n = 0;
   int          last_n = 0;
   longint      cyc = 0;
   longint      arm_cyc = 0;
   longint      done_cyc = -1000;
   longint      last_gap = 0;
   bit          last_acc_done = 1'b0;
   int          n_glitch = 0;
   int          n_done = 0;

   initial begin
      frame_t f;
      frame_t g;
      logic   prev_tx   = 1'b1;
      logic   prev_tick = 1'b0;
      logic   prev_rst  = 1'b1;
      forever begin
         @(negedge clock);
         cyc++;
         if (!reset_n) begin
            exp_q.delete();
            obs_n    = 0;
            obs_bits = '0;
         end else begin
            if (m_tx !== prev_tx && !prev_tick && !prev_rst) n_glitch++;
            if (baud_tick && m_busy) begin
               if (obs_n == 0) begin
                  arm_cyc  = cyc;
                  last_gap = cyc - done_cyc;
               end
               if (obs_n < 16) obs_bits[obs_n] = m_tx;
               obs_n++;
            end
            if (m_done) begin
               n_done++;
               check_val("done_has_frame", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  f = exp_q.pop_front();
                  check_val("frame_bits", 32'(obs_bits), 32'(f.bits));
                  check_val("frame_len", 32'(obs_n), 32'(f.n));
                  check_val("frame_cycles", 32'(cyc - arm_cyc), 32'((f.n - 1) * tick_period + 1));
               end
               last_bits = obs_bits;
               last_n    = obs_n;
               done_cyc  = cyc;
               obs_bits  = '0;
               obs_n     = 0;
            end
            if (m_valid && m_ready) begin
               g = model_frame(tx_data, sel ? 7 : 8, sel ? 2 : 1);
               exp_q.push_back(g);
               last_acc_done = m_done;
            end
         end
         prev_tx   = m_tx;
         prev_tick = baud_tick;
         prev_rst  = !reset_n;
      end
   end

   task automatic drive_valid(input logic v);
      if (sel) tx_valid_b = v;
      else     tx_valid_a = v;
   endtask

   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic send(input logic [7:0] d, input bit keep);
      bit got = 1'b0;
      tx_data = d;
      drive_valid(1'b1);
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clock);
         if (m_valid && m_ready) got = 1'b1;
      end
      check_val("accept_timeout", 32'(got), 32'd1);
      @(posedge clock);
      #2;
      if (!keep) begin
         drive_valid(1'b0);
         tx_data = 8'($urandom);
      end
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(posedge clock);
         #2;
         if (!m_busy && m_ready && exp_q.size() == 0) ok = 1'b1;
      end
      check_val("idle_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  done_before;
      bit  found;
      reset_n    = 1'b0;
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
      tx_data    = 8'h00;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_val("rst_tx_a", 32'(tx_a), 32'd1);
      check_val("rst_ready_a", 32'(tx_ready_a), 32'd1);
      check_val("rst_busy_a", 32'(busy_a), 32'd0);
      check_val("rst_done_a", 32'(done_a), 32'd0);
      check_val("rst_tx_b", 32'(tx_b), 32'd1);
      check_val("rst_ready_b", 32'(tx_ready_b), 32'd1);
      check_val("rst_busy_b", 32'(busy_b), 32'd0);
      check_val("rst_done_b", 32'(done_b), 32'd0);
      @(posedge clock);
      #2;
      reset_n = 1'b1;
      repeat (3) @(posedge clock);
      #2;

      // 0xA5 on an every-4-clock tick grid
      sel = 1'b0;
      tick_period = 4;
      done_before = n_done;
      send(8'hA5, 1'b0);
      wait_idle();
      check_val("a5_bits", 32'(last_bits), PAR ? 32'hA95 : 32'h695);
      check_val("a5_len", 32'(last_n), PAR ? 32'd12 : 32'd11);
      check_val("a5_done_once", 32'(n_done - done_before), 32'd1);

      // tx_valid in a tick cycle while idle: tick ignored, start waits for next tick
      tick_period = 5;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clock);
         #2;
         if (baud_tick) found = 1'b1;
      end
      tx_data = 8'h3C;
      drive_valid(1'b1);
      @(negedge clock);
      check_val("tick_accept_ready", 32'(tx_ready_a), 32'd1);
      @(posedge clock);
      #2;
      drive_valid(1'b0);
      @(negedge clock);
      check_val("arm_busy", 32'(busy_a), 32'd1);
      check_val("arm_tx", 32'(tx_a), 32'd1);
      check_val("arm_ready", 32'(tx_ready_a), 32'd0);
      wait_idle();

      // Reset in the middle of the data bits
      tick_period = 3;
      send(8'hC3, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clock);
         #2;
         if (obs_n >= 5) found = 1'b1;
      end
      check_val("reach_data", 32'(found), 32'd1);
      reset_n = 1'b0;
      @(posedge clock);
      #2;
      reset_n = 1'b1;
      @(negedge clock);
      check_val("midrst_tx", 32'(tx_a), 32'd1);
      check_val("midrst_busy", 32'(busy_a), 32'd0);
      check_val("midrst_ready", 32'(tx_ready_a), 32'd1);
      check_val("midrst_done", 32'(done_a), 32'd0);
      done_before = n_done;
      repeat (80) @(posedge clock);
      #2;
      check_val("midrst_no_done", 32'(n_done), 32'(done_before));

      // Back-to-back 0x00 then 0xFF with tx_valid held
      send(8'h00, 1'b1);
      send(8'hFF, 1'b0);
      check_val("b2b_accept_in_done", 32'(last_acc_done), 32'd1);
      wait_idle();
      check_val("b2b_gap", 32'(last_gap), 32'(tick_period - 1));

      // 7 data bits, 2 stop bits
      sel = 1'b1;
      tick_period = 4;
      repeat (2) @(posedge clock);
      #2;
      send(8'h41, 1'b0);
      wait_idle();
      check_val("b41_bits", 32'(last_bits), PAR ? 32'hD05 : 32'h705);
      check_val("b41_len", 32'(last_n), PAR ? 32'd12 : 32'd11);

`ifdef UART_TX_PARITY_EN
      sel = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      send(8'h07, 1'b0);
      wait_idle();
      check_val("parity_07", 32'(last_bits[10]), 32'd1);
      send(8'h03, 1'b0);
      wait_idle();
      check_val("parity_03", 32'(last_bits[10]), 32'd0);
`endif

      // Random frames, tick periods, gaps and back-to-back pairs
      for (int it = 0; it < 40; it++) begin
         sel = 1'($urandom_range(0, 1));
         tick_period = int'($urandom_range(1, 6));
         repeat ($urandom_range(1, 7)) @(posedge clock);
         #2;
         if ($urandom_range(0, 3) == 0) begin
            send(8'($urandom), 1'b1);
            send(8'($urandom), 1'b0);
         end else begin
            send(8'($urandom), 1'b0);
         end
         wait_idle();
      end

      check_val("no_tx_glitch", 32'(n_glitch), 32'd0);
      check_val("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
